// File: rtl/eth_pkg.sv
// Shared Ethernet receive definitions: framing bytes, CRC-32 constants,
// the receive FSM state type and a one-byte reflected CRC-32 step.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
    localparam logic [7:0]  ETH_SFD         = 8'hD5;
    localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB20E3;

    // Depth of the delay line that holds back the trailing FCS bytes.
    localparam int BUF_DEPTH = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_DROP
    } rx_state_e;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ ETH_CRC_POLY;
            else                c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_fcs32.sv
// Byte-wide Ethernet CRC-32 register: init reloads the seed, en folds in one
// LSB-first byte. The register is not complemented; callers compare residues.
module eth_fcs32
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    // NOTE: next-state logic gets a full default first so no path can infer a latch.
    always_comb begin
        crc_d = crc_q;
        if (init)    crc_d = ETH_CRC_INIT;
        else if (en) crc_d = crc32_byte(crc_q, data);
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) crc_q <= ETH_CRC_INIT;
        else     crc_q <= crc_d;
    end

    assign crc = crc_q;

endmodule

// File: rtl/eth_rx_fcs_check.sv
// Receive FCS checker: locks onto preamble/SFD, streams the frame out five
// bytes late so the FCS is stripped, and pulses per-frame status at the end.
module eth_rx_fcs_check
    import eth_pkg::*;
#(
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518,
    parameter int LEN_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_er,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_sof,
    output logic             out_last,
    output logic             frame_done,
    output logic             frame_ok,
    output logic             crc_err,
    output logic             len_err,
    output logic             phy_err,
    output logic [LEN_W-1:0] frame_len
);

    rx_state_e        state_q, state_d;
    logic [7:0]       buf_q [BUF_DEPTH];
    logic [7:0]       buf_d [BUF_DEPTH];
    logic [2:0]       fill_q, fill_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             er_q, er_d;
    logic             sof_pend_q, sof_pend_d;
    logic             idle_seen_q, idle_seen_d;

    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_sof_q, out_sof_d;
    logic             out_last_q, out_last_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_ok_q, frame_ok_d;
    logic             crc_err_q, crc_err_d;
    logic             len_err_q, len_err_d;
    logic             phy_err_q, phy_err_d;
    logic [LEN_W-1:0] frame_len_q, frame_len_d;

    logic             crc_init;
    logic             crc_en;
    logic [31:0]      crc_val;
    logic             buf_full;

    eth_fcs32 u_fcs (
        .clk  (clk),
        .rst  (rst),
        .init (crc_init),
        .en   (crc_en),
        .data (in_data),
        .crc  (crc_val)
    );

    assign buf_full = (fill_q == 3'(BUF_DEPTH));

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        fill_d       = fill_q;
        len_d        = len_q;
        er_d         = er_q;
        sof_pend_d   = sof_pend_q;
        // Only a rising in_valid may open a frame, so a frame cut by reset is skipped.
        idle_seen_d  = !in_valid;
        out_valid_d  = 1'b0;
        out_data_d   = 8'h00;
        out_sof_d    = 1'b0;
        out_last_d   = 1'b0;
        frame_done_d = 1'b0;
        frame_ok_d   = 1'b0;
        crc_err_d    = 1'b0;
        len_err_d    = 1'b0;
        phy_err_d    = 1'b0;
        frame_len_d  = '0;
        crc_init     = 1'b0;
        crc_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (in_data == ETH_PREAMBLE && idle_seen_q) state_d = ST_PREAMBLE;
                    else                                         state_d = ST_DROP;
                end
            end

            ST_PREAMBLE: begin
                if (!in_valid) begin
                    state_d = ST_IDLE;
                end else if (in_data == ETH_SFD) begin
                    state_d    = ST_DATA;
                    crc_init   = 1'b1;
                    len_d      = '0;
                    fill_d     = '0;
                    er_d       = 1'b0;
                    sof_pend_d = 1'b1;
                end else if (in_data != ETH_PREAMBLE) begin
                    state_d = ST_DROP;
                end
            end

            ST_DATA: begin
                if (in_valid) begin
                    crc_en = 1'b1;
                    len_d  = (&len_q) ? len_q : len_q + 1'b1;
                    er_d   = er_q | in_er;
                    if (buf_full) begin
                        out_valid_d = 1'b1;
                        out_data_d  = buf_q[0];
                        out_sof_d   = sof_pend_q;
                        sof_pend_d  = 1'b0;
                    end else begin
                        fill_d = fill_q + 3'd1;
                    end
                    for (int i = 0; i < BUF_DEPTH - 1; i++) buf_d[i] = buf_q[i+1];
                    buf_d[BUF_DEPTH-1] = in_data;
                end else begin
                    // Buffer now holds the last payload byte plus the four FCS bytes.
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                    frame_len_d  = len_q;
                    crc_err_d    = (crc_val != ETH_CRC_RESIDUE);
                    len_err_d    = (len_q < LEN_W'(MIN_FRAME_LEN)) ||
                                   (len_q > LEN_W'(MAX_FRAME_LEN));
                    phy_err_d    = er_q;
                    frame_ok_d   = !crc_err_d && !len_err_d && !phy_err_d;
                    if (buf_full) begin
                        out_valid_d = 1'b1;
                        out_data_d  = buf_q[0];
                        out_sof_d   = sof_pend_q;
                        out_last_d  = 1'b1;
                    end
                end
            end

            ST_DROP: begin
                if (!in_valid) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            fill_q       <= '0;
            len_q        <= '0;
            er_q         <= 1'b0;
            sof_pend_q   <= 1'b0;
            idle_seen_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
            out_sof_q    <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            crc_err_q    <= 1'b0;
            len_err_q    <= 1'b0;
            phy_err_q    <= 1'b0;
            frame_len_q  <= '0;
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            len_q        <= len_d;
            er_q         <= er_d;
            sof_pend_q   <= sof_pend_d;
            idle_seen_q  <= idle_seen_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sof_q    <= out_sof_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
            frame_ok_q   <= frame_ok_d;
            crc_err_q    <= crc_err_d;
            len_err_q    <= len_err_d;
            phy_err_q    <= phy_err_d;
            frame_len_q  <= frame_len_d;
        end
    end

    // NOTE: the delay line is not reset; fill_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_sof    = out_sof_q;
    assign out_last   = out_last_q;
    assign frame_done = frame_done_q;
    assign frame_ok   = frame_ok_q;
    assign crc_err    = crc_err_q;
    assign len_err    = len_err_q;
    assign phy_err    = phy_err_q;
    assign frame_len  = frame_len_q;

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Scoreboard bench: two checkers (MIN_FRAME_LEN 13 and default) share one
// randomized receive stream; a frame-level model predicts payload and status.
module tb_eth_rx_fcs_check;

    localparam logic [31:0] POLY    = 32'hEDB88320;
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
    localparam int          MIN_A   = 13;
    localparam int          MIN_B   = 64;
    localparam int          MAX_LEN = 1518;

    typedef logic [7:0] bq_t[$];
    typedef struct { logic [7:0] data; logic sof; logic last; } pay_t;
    typedef struct { logic ok; logic crc_err; logic len_err; logic phy_err; logic [15:0] len; } st_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic in_er = 1'b0;

    logic a_out_valid, a_out_sof, a_out_last, a_frame_done, a_frame_ok, a_crc_err, a_len_err, a_phy_err;
    logic [7:0] a_out_data;
    logic [15:0] a_frame_len;
    logic b_out_valid, b_out_sof, b_out_last, b_frame_done, b_frame_ok, b_crc_err, b_len_err, b_phy_err;
    logic [7:0] b_out_data;
    logic [15:0] b_frame_len;

    int total = 0;
    int bad = 0;

    pay_t pay_a[$];
    pay_t pay_b[$];
    st_t  st_a[$];
    st_t  st_b[$];

    always #5 clk = ~clk;

    eth_rx_fcs_check #(.MIN_FRAME_LEN(MIN_A)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_er(in_er),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_sof(a_out_sof), .out_last(a_out_last),
        .frame_done(a_frame_done), .frame_ok(a_frame_ok), .crc_err(a_crc_err),
        .len_err(a_len_err), .phy_err(a_phy_err), .frame_len(a_frame_len)
    );

    eth_rx_fcs_check u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_er(in_er),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_sof(b_out_sof), .out_last(b_out_last),
        .frame_done(b_frame_done), .frame_ok(b_frame_ok), .crc_err(b_crc_err),
        .len_err(b_len_err), .phy_err(b_phy_err), .frame_len(b_frame_len)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Plain CRC-32 over a whole byte sequence, each byte LSB first.
    function automatic logic [31:0] crc_of(input bq_t f);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (f[k]) begin
            for (int i = 0; i < 8; i++) begin
                logic fb = c[0] ^ f[k][i];
                c = c >> 1;
                if (fb) c = c ^ POLY;
            end
        end
        return c;
    endfunction

    function automatic bq_t with_fcs(input bq_t p);
        bq_t f = p;
        logic [31:0] fcs = ~crc_of(p);
        for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
        return f;
    endfunction

    function automatic st_t status_for(input bq_t f, input logic er, input int min_len);
        st_t s;
        s.len     = 16'(f.size());
        s.crc_err = (crc_of(f) != RESIDUE);
        s.len_err = (f.size() < min_len) || (f.size() > MAX_LEN);
        s.phy_err = er;
        s.ok      = !s.crc_err && !s.len_err && !s.phy_err;
        return s;
    endfunction

    // emit < 0: whole frame completes; otherwise only the first emit bytes appear.
    task automatic expect_frame(input bq_t f, input logic er, input int emit);
        int n = f.size();
        int npay = (n >= 5) ? n - 4 : 0;
        int lim = (emit < 0) ? npay : emit;
        for (int i = 0; i < lim; i++) begin
            pay_t p;
            p.data = f[i];
            p.sof  = (i == 0);
            p.last = (emit < 0) && (i == npay - 1);
            pay_a.push_back(p);
            pay_b.push_back(p);
        end
        if (emit < 0) begin
            st_a.push_back(status_for(f, er, MIN_A));
            st_b.push_back(status_for(f, er, MIN_B));
        end
    endtask

    task automatic drive(input logic [7:0] b, input logic er);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        in_er    = er;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'h00;
            in_er    = 1'b0;
        end
    endtask

    task automatic send_frame(input bq_t f, input int er_idx, input int gap);
        expect_frame(f, er_idx >= 0 && er_idx < f.size(), -1);
        repeat (7) drive(8'h55, 1'b0);
        drive(8'hD5, 1'b0);
        foreach (f[i]) drive(f[i], i == er_idx);
        idle(gap);
    endtask

    function automatic bq_t rand_bytes(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_a"}, {a_out_valid, a_out_data, a_out_sof, a_out_last, a_frame_done,
                            a_frame_ok, a_crc_err, a_len_err, a_phy_err, a_frame_len}, 32'h0);
        check({tag, "_b"}, {b_out_valid, b_out_data, b_out_sof, b_out_last, b_frame_done,
                            b_frame_ok, b_crc_err, b_len_err, b_phy_err, b_frame_len}, 32'h0);
    endtask

    task automatic cmp_pay(input string side, input pay_t got, input pay_t exp);
        check({side, "_data"}, 32'(got.data), 32'(exp.data));
        check({side, "_sof"},  32'(got.sof),  32'(exp.sof));
        check({side, "_last"}, 32'(got.last), 32'(exp.last));
    endtask

    task automatic cmp_st(input string side, input st_t got, input st_t exp);
        check({side, "_frame_len"}, 32'(got.len),     32'(exp.len));
        check({side, "_crc_err"},   32'(got.crc_err), 32'(exp.crc_err));
        check({side, "_len_err"},   32'(got.len_err), 32'(exp.len_err));
        check({side, "_phy_err"},   32'(got.phy_err), 32'(exp.phy_err));
        check({side, "_frame_ok"},  32'(got.ok),      32'(exp.ok));
    endtask

    // Monitors: pop and compare whenever a checker presents a byte or a status.
    always @(negedge clk) begin
        if (a_out_valid) begin
            if (pay_a.size() == 0) check("a_unexpected_byte", 32'(a_out_data), 32'hFFFF_FFFF);
            else cmp_pay("a", '{a_out_data, a_out_sof, a_out_last}, pay_a.pop_front());
        end
        if (a_frame_done) begin
            if (st_a.size() == 0) check("a_unexpected_done", 32'(a_frame_len), 32'hFFFF_FFFF);
            else cmp_st("a", '{a_frame_ok, a_crc_err, a_len_err, a_phy_err, a_frame_len}, st_a.pop_front());
        end
    end

    always @(negedge clk) begin
        if (b_out_valid) begin
            if (pay_b.size() == 0) check("b_unexpected_byte", 32'(b_out_data), 32'hFFFF_FFFF);
            else cmp_pay("b", '{b_out_data, b_out_sof, b_out_last}, pay_b.pop_front());
        end
        if (b_frame_done) begin
            if (st_b.size() == 0) check("b_unexpected_done", 32'(b_frame_len), 32'hFFFF_FFFF);
            else cmp_st("b", '{b_frame_ok, b_crc_err, b_len_err, b_phy_err, b_frame_len}, st_b.pop_front());
        end
    end

    initial begin
        bq_t f, g;

        idle(4);
        check_all_zero("reset_state");
        rst = 1'b0;
        idle(3);

        // Known-good "123456789" frame and a corrupted-FCS copy.
        f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'h26, 8'h39, 8'hF4, 8'hCB};
        send_frame(f, -1, 3);
        g = f;
        g[12] = 8'hCA;
        send_frame(g, -1, 3);

        // Minimum legal length for default params, then one byte short.
        g = {};
        for (int i = 0; i < 60; i++) g.push_back(8'(i));
        send_frame(with_fcs(g), -1, 2);
        void'(g.pop_back());
        send_frame(with_fcs(g), -1, 2);

        // Broken preamble: nothing may come out; the following frame is normal.
        drive(8'h55, 1'b0);
        drive(8'h55, 1'b0);
        drive(8'h57, 1'b0);
        g = rand_bytes(12);
        foreach (g[i]) drive(g[i], 1'b0);
        idle(2);
        send_frame(f, -1, 3);

        // PHY error on payload byte 10.
        send_frame(with_fcs(rand_bytes(64)), 10, 3);

        // Reset while byte 20 is on the wire: bytes 0..14 already left, then silence.
        g = with_fcs(rand_bytes(40));
        expect_frame(g, 1'b0, 15);
        repeat (7) drive(8'h55, 1'b0);
        drive(8'hD5, 1'b0);
        for (int i = 0; i < 20; i++) drive(g[i], 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = g[20];
        rst      = 1'b1;
        @(negedge clk);
        check_all_zero("mid_frame_reset");
        rst     = 1'b0;
        in_data = g[21];
        for (int i = 22; i < g.size(); i++) drive(g[i], 1'b0);
        idle(3);
        send_frame(with_fcs(rand_bytes(70)), -1, 3);

        // Back-to-back frames with a single idle cycle between them.
        send_frame(with_fcs(rand_bytes(62)), -1, 1);
        send_frame(with_fcs(rand_bytes(20)), -1, 1);
        send_frame(with_fcs(rand_bytes(1)), -1, 1);

        // Very short frames: no payload below five bytes.
        send_frame(rand_bytes(3), -1, 2);
        send_frame(rand_bytes(4), -1, 2);
        send_frame(with_fcs(rand_bytes(1)), -1, 2);

        // Randomized traffic.
        for (int k = 0; k < 10; k++) begin
            g = with_fcs(rand_bytes($urandom_range(0, 90)));
            if ($urandom_range(0, 3) == 0) g[$urandom_range(0, g.size() - 1)] ^= 8'(1 << $urandom_range(0, 7));
            send_frame(g, ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, g.size() - 1)) : -1,
                       $urandom_range(1, 4));
        end

        idle(12);
        check("a_pay_left", 32'(pay_a.size()), 32'd0);
        check("b_pay_left", 32'(pay_b.size()), 32'd0);
        check("a_status_left", 32'(st_a.size()), 32'd0);
        check("b_status_left", 32'(st_b.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eth_rx_fcs_check.md
Name: eth_rx_fcs_check

Overview:
Receive-side companion to the transmit FCS generator. It takes the raw MAC receive byte stream (preamble, SFD, frame, FCS), finds the SFD and runs CRC-32 over every frame byte including the FCS. It delays the stream by a 5-byte buffer so the 4 FCS bytes are stripped, and reports per-frame status: CRC, length and PHY error. It sits between the PHY byte interface (RMII/GMII byte assembler) and the frame parser / UDP command decoder.

Parameters:
MIN_FRAME_LEN, 64, minimum legal frame length in bytes, counted from destination MAC to FCS inclusive
MAX_FRAME_LEN, 1518, maximum legal frame length in bytes, same counting
LEN_W, 16, width of the length counter; saturates at all-ones

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  PHY data valid (rx_dv); contiguous for a whole frame
in_data  in  8  received byte, LSB-first bit order as delivered by the PHY
in_er  in  1  PHY receive error; sampled only while in_valid=1
out_valid  out  1  payload byte valid (FCS excluded)
out_data  out  8  payload byte
out_sof  out  1  marks the first payload byte
out_last  out  1  marks the last payload byte
frame_done  out  1  one-cycle end-of-frame status strobe
frame_ok  out  1  qualified by frame_done: CRC good, length legal, no in_er
crc_err  out  1  qualified by frame_done
len_err  out  1  qualified by frame_done
phy_err  out  1  qualified by frame_done
frame_len  out  LEN_W  qualified by frame_done: byte count including FCS

Behaviour:
- Reset: all outputs are 0, FSM is in IDLE, the buffer fill count is 0 and the CRC register is 0xFFFFFFFF. A reset mid-frame discards the frame with no frame_done; any in-progress bytes are ignored until in_valid goes low.
- FSM states: IDLE, PREAMBLE, DATA, DROP.
  - IDLE: in_valid=1 and byte 0x55 -> PREAMBLE. Any other byte with in_valid=1 -> DROP.
  - PREAMBLE: 0x55 -> stay. 0xD5 -> DATA, pulsing CRC init and clearing the length counter and fill count. Any other byte -> DROP. in_valid=0 -> IDLE silently.
  - DATA: each byte with in_valid=1 is fed to the CRC, shifted into the 5-byte buffer and increments frame_len (saturating). in_valid=0 -> end-of-frame handling, then IDLE.
  - DROP: wait for in_valid=0, then IDLE. No outputs are produced.
- Streaming: in the cycle after byte n+5 is sampled, out_valid=1 and out_data=byte n. out_sof=1 for byte 0.
- End of frame: frame ends when in_valid=0 is sampled in DATA. In the next cycle:
  - frame_done=1 with the status bits and frame_len;
  - if N≥5, out_valid=1, out_data=byte N-5 and out_last=1, all in the same cycle as frame_done;
  - if N≤4, no payload byte is emitted and the status still pulses;
  - if N=5, out_sof and out_last are both asserted.
- CRC: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, bitwise LSB-first per byte. crc_err=0 exactly when the register equals residue 0xDEBB20E3 after the last byte.
- Length: len_err=1 if frame_len<MIN_FRAME_LEN or frame_len>MAX_FRAME_LEN.
- PHY error: phy_err=1 if in_er was 1 on any DATA-state byte.
- Status combination: frame_ok = !crc_err & !len_err & !phy_err.
- Inter-frame gap: a new preamble may start on the cycle after in_valid falls. The end-of-frame outputs for the previous frame still appear; the buffer is cleared on the new SFD.
- No backpressure: the downstream must accept one byte per cycle.

Decomposition:
- Shared package eth_pkg holds:
  - ETH_PREAMBLE = 8'h55, ETH_SFD = 8'hD5;
  - ETH_CRC_POLY = 32'hEDB88320, ETH_CRC_INIT = 32'hFFFFFFFF, ETH_CRC_RESIDUE = 32'hDEBB20E3;
  - the FSM state enum.
- Sub-module: reuse the existing eth_fcs32 instance. Drive init on SFD detection and en for each DATA-state byte. No new CRC logic.

Test Plan:
- Known-good frame: 7×0x55, 0xD5, ASCII "123456789" (0x31..0x39), FCS 0x26 0x39 0xF4 0xCB, with MIN_FRAME_LEN=13 -> 9 payload bytes out (sof on 0x31, last on 0x39); frame_done with frame_ok=1 and frame_len=13.
- Same frame with FCS byte 0xCB changed to 0xCA -> payload still streamed; crc_err=1, frame_ok=0.
- 60-byte payload 0x00..0x3B plus model-computed FCS, default params -> frame_len=64, frame_ok=1. The same traffic shortened to 59 bytes -> len_err=1.
- Preamble 0x55,0x55,0x57,… -> DROP: no out_valid and no frame_done until in_valid falls; the next good frame is received correctly.
- in_er pulsed on payload byte 10 -> phy_err=1, frame_ok=0. Separately, rst asserted at payload byte 20 -> no frame_done, all outputs 0, and the following frame is clean.
- Back-to-back frames with a 1-cycle gap -> both frame_done pulses are present with correct lengths, and out_sof/out_last are not merged across frames.
